// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcodes, step encodings, ALU codes and strobe bundle for the
//            hardwired control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;

    typedef enum logic [3:0] {
        S_T0   = 4'h0, S_T1 = 4'h1, S_T2 = 4'h2, S_T3 = 4'h3,
        S_T4   = 4'h4, S_T5 = 4'h5, S_T6 = 4'h6, S_T7 = 4'h7,
        S_HALT = 4'hE,
        S_RST  = 4'hF
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LDI, CL_LD, CL_ST, CL_BR, CL_NOP, CL_HALT
    } op_class_t;

    typedef struct packed {
        logic pc_out;   logic pc_in;    logic inc_pc;   logic mar_in;
        logic mdr_in;   logic mdr_out;  logic read;     logic write;
        logic ir_in;    logic y_in;     logic zlow_in;  logic zlow_out;
        logic gra;      logic grb;      logic grc;      logic r_in;
        logic r_out;    logic ba_out;   logic csign_out; logic con_in;
    } strobes_t;

    // Unlisted opcodes fall into the nop class.
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return CL_ALU;
            OP_LDI:  return CL_LDI;
            OP_LD:   return CL_LD;
            OP_ST:   return CL_ST;
            OP_BR:   return CL_BR;
            OP_HALT: return CL_HALT;
            default: return CL_NOP;
        endcase
    endfunction

    function automatic state_t last_step(input op_class_t cl);
        case (cl)
            CL_ALU, CL_LDI: return S_T5;
            CL_LD, CL_ST:   return S_T7;
            CL_BR:          return S_T6;
            default:        return S_T3;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_step_decoder.sv
// ============================================================================
// Module   : step_decoder
// Brief    : Combinational decode of (step, opcode, CONFF) into strobe bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  state_t          state,
    input  logic [OPW-1:0]  opcode,
    input  logic            conff,
    output strobes_t        strobes,
    output logic [ALUW-1:0] alu_op
);

    op_class_t w_class;
    assign w_class = op_class(5'(opcode));

    always_comb begin
        strobes = '0;
        alu_op  = '0;
        case (state)
            S_T0: begin
                strobes.pc_out  = 1'b1; strobes.mar_in = 1'b1;
                strobes.inc_pc  = 1'b1; strobes.zlow_in = 1'b1;
            end
            S_T1: begin
                strobes.zlow_out = 1'b1; strobes.pc_in  = 1'b1;
                strobes.read     = 1'b1; strobes.mdr_in = 1'b1;
            end
            S_T2: begin
                strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
            end
            S_T3: begin
                case (w_class)
                    CL_ALU: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CL_BR: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_class)
                    CL_ALU: begin
                        strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.zlow_in = 1'b1;
                        alu_op = ALUW'(alu_code(5'(opcode)));
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        strobes.csign_out = 1'b1; strobes.zlow_in = 1'b1;
                        alu_op = ALUW'(ALU_ADD);
                    end
                    CL_BR: begin
                        strobes.pc_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_class)
                    CL_ALU, CL_LDI: begin
                        strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1;
                    end
                    CL_BR: begin
                        strobes.csign_out = 1'b1; strobes.zlow_in = 1'b1;
                        alu_op = ALUW'(ALU_ADD);
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_class)
                    CL_LD: begin
                        strobes.read = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    CL_ST: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    CL_BR: begin
                        strobes.zlow_out = 1'b1; strobes.pc_in = conff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (w_class)
                    CL_LD: begin
                        strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    CL_ST:   strobes.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired control unit: fetch T0-T2, execute T3-T7, halt/pause.
//            Define MEM_WAIT_EN to stretch memory steps until mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            CONFF,
    input  logic            stop,
    input  logic            mem_ready,
    output logic            PCout, PCin, IncPC, MARin, MDRin, MDRout,
    output logic            Read, Write, IRin, Yin, Zlowin, Zlowout,
    output logic            Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin,
    output logic [ALUW-1:0] ALUop,
    output logic            run
);

    state_t          r_state;
    logic            r_paused;
    logic [OPW-1:0]  w_opcode;
    op_class_t       w_class;
    state_t          w_last_step;
    logic            w_hold;
    logic            w_active;
    strobes_t        w_strobes;
    logic [ALUW-1:0] w_alu_op;
    logic            w_unused;

    assign w_opcode    = IR[31 -: OPW];
    assign w_class     = op_class(5'(w_opcode));
    assign w_last_step = last_step(w_class);
    assign w_unused    = ^{IR[31-OPW:0], mem_ready};

`ifdef MEM_WAIT_EN
    assign w_hold = !mem_ready && ((r_state == S_T1) ||
                                   (r_state == S_T6 && w_class == CL_LD) ||
                                   (r_state == S_T7 && w_class == CL_ST));
`else
    assign w_hold = 1'b0;
`endif

    // A pause is T0 with r_paused set; stop is only sampled when an instruction retires.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state  <= S_RST;
            r_paused <= 1'b0;
        end else begin
            case (r_state)
                S_RST: begin
                    r_state  <= S_T0;
                    r_paused <= 1'b0;
                end
                S_HALT: r_state <= S_HALT;
                S_T0: begin
                    if (r_paused) begin
                        if (!stop) r_paused <= 1'b0;
                    end else begin
                        r_state <= S_T1;
                    end
                end
                S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                    if (!w_hold) begin
                        if (r_state == S_T3 && w_class == CL_HALT) begin
                            r_state <= S_HALT;
                        end else if (r_state >= w_last_step) begin
                            r_state  <= S_T0;
                            r_paused <= stop;
                        end else begin
                            r_state <= state_t'(r_state + 4'd1);
                        end
                    end
                end
                default: begin
                    r_state  <= S_T0;
                    r_paused <= 1'b0;
                end
            endcase
        end
    end

    step_decoder #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_step_decoder (
        .state   (r_state),
        .opcode  (w_opcode),
        .conff   (CONFF),
        .strobes (w_strobes),
        .alu_op  (w_alu_op)
    );

    assign w_active = !r_paused && (r_state <= S_T7);
    assign run      = w_active;

    assign PCout    = w_active & w_strobes.pc_out;
    assign PCin     = w_active & w_strobes.pc_in;
    assign IncPC    = w_active & w_strobes.inc_pc;
    assign MARin    = w_active & w_strobes.mar_in;
    assign MDRin    = w_active & w_strobes.mdr_in;
    assign MDRout   = w_active & w_strobes.mdr_out;
    assign Read     = w_active & w_strobes.read;
    assign Write    = w_active & w_strobes.write;
    assign IRin     = w_active & w_strobes.ir_in;
    assign Yin      = w_active & w_strobes.y_in;
    assign Zlowin   = w_active & w_strobes.zlow_in;
    assign Zlowout  = w_active & w_strobes.zlow_out;
    assign Gra      = w_active & w_strobes.gra;
    assign Grb      = w_active & w_strobes.grb;
    assign Grc      = w_active & w_strobes.grc;
    assign Rin      = w_active & w_strobes.r_in;
    assign Rout     = w_active & w_strobes.r_out;
    assign BAout    = w_active & w_strobes.ba_out;
    assign Csignout = w_active & w_strobes.csign_out;
    assign CONin    = w_active & w_strobes.con_in;
    assign ALUop    = w_active ? w_alu_op : '0;

endmodule

`default_nettype wire
